// File: rtl/carry_lookahead_adder_aor_pipe.sv
// ---------------------------------------------------------------------------
// carry_lookahead_adder_aor_pipe
//
// Pipelined carry lookahead adder whose carry-generate terms pass through
// AND/OR key gates. A key is shifted in serially and held on-chip. With the
// correct key every gate is transparent and the block is a plain adder; with
// any other key some generate terms are forced and the sums are silently
// wrong.
//
// The adder is split into STAGES slices of WIDTH/STAGES bits. Slice k is
// computed in pipeline stage k out of 4-bit lookahead groups. The carry out
// of each slice is registered together with the upper operand bits and the
// finished lower sum bits.
//
// Optional feature macro: CLA_BACKPRESSURE_EN
//   defined   : adds out_ready_i; the pipeline only advances when the output
//               register is empty or being taken.
//   undefined : the pipeline advances every cycle.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   key_sin_i    serial key data, first bit ends at the key MSB
//   key_shift_i  shift key_sin_i in this cycle (also flushes the pipeline)
//   key_armed_o  a full key has been loaded since the last reset/reload start
//   in_valid_i   operands valid
//   in_ready_o   operands accepted this cycle when high
//   add1_i       operand A
//   add2_i       operand B
//   out_valid_o  result valid
//   out_ready_i  consumer takes the result (CLA_BACKPRESSURE_EN only)
//   result_o     {carry_out, sum}, held while out_valid_o is low
// ---------------------------------------------------------------------------
module carry_lookahead_adder_aor_pipe #(
  parameter int WIDTH = 16,
  parameter int STAGES = 2,
  parameter int KEY_WIDTH = 32,
  parameter logic [KEY_WIDTH-1:0] CORRECT_KEY = KEY_WIDTH'(32'hD7D41D23)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             key_sin_i,
  input  logic             key_shift_i,
  output logic             key_armed_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  output logic             out_valid_o,
`ifdef CLA_BACKPRESSURE_EN
  input  logic             out_ready_i,
`endif
  output logic [WIDTH:0]   result_o
);

  localparam int SLICE_W = WIDTH / STAGES;
  localparam int GROUPS  = SLICE_W / 4;
  localparam int CNT_W   = $clog2(KEY_WIDTH + 1);

  typedef enum logic [1:0] {
    UNKEYED,
    LOADING,
    ARMED
  } key_state_e;

  key_state_e           state_q;
  logic [CNT_W-1:0]     count_q;
  logic [KEY_WIDTH-1:0] key_q;
  logic [KEY_WIDTH-1:0] key_shifted;
  logic                 armed_q;
  logic                 advance;
  logic                 accept;
  logic                 out_valid_q;
  logic [WIDTH:0]       result_q;

  // Inputs of each stage; stage 0 is fed straight from the ports.
  logic [WIDTH-1:0] st_a   [STAGES];
  logic [WIDTH-1:0] st_b   [STAGES];
  logic [WIDTH-1:0] st_sum [STAGES];
  logic             st_c   [STAGES];
  logic             st_v   [STAGES];

  // Next key value: shift left, new bit enters at the LSB so the first
  // bit shifted in ends up at the MSB once the key is complete.
  always_comb begin
    key_shifted    = key_q << 1;
    key_shifted[0] = key_sin_i;
  end

  // Key loader FSM. Any shift restarts or continues loading; the armed flag
  // is kept as its own register so key_armed_o comes straight from a flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= UNKEYED;
      count_q <= '0;
      key_q   <= '0;
      armed_q <= 1'b0;
    end else if (key_shift_i) begin
      key_q <= key_shifted;
      if (state_q == LOADING) begin
        count_q <= count_q + CNT_W'(1);
        if (count_q == CNT_W'(KEY_WIDTH - 1)) begin
          state_q <= ARMED;
          armed_q <= 1'b1;
        end
      end else begin
        count_q <= CNT_W'(1);
        if (KEY_WIDTH == 1) begin
          state_q <= ARMED;
          armed_q <= 1'b1;
        end else begin
          state_q <= LOADING;
          armed_q <= 1'b0;
        end
      end
    end
  end

  // Pipeline advance condition.
`ifdef CLA_BACKPRESSURE_EN
  assign advance = !out_valid_q || out_ready_i;
`else
  assign advance = 1'b1;
`endif

  // A key shift blocks new operands so no beat ever straddles two keys.
  assign in_ready_o = armed_q && !key_shift_i && advance;
  assign accept     = in_valid_i && in_ready_o;

  assign st_a[0]   = add1_i;
  assign st_b[0]   = add2_i;
  assign st_sum[0] = '0;
  assign st_c[0]   = 1'b0;
  assign st_v[0]   = accept;

  // Adds one slice of the operands. Generate terms are first passed through
  // the key gates in ascending key-bit order (key bits beyond WIDTH wrap
  // around onto the same generate terms again). Inside the slice each 4-bit
  // group resolves its internal carries and its group generate/propagate in
  // two-level form, and the group carry feeds the next group. Sum bits
  // outside the slice are taken over from sum_in unchanged.
  function automatic logic [WIDTH:0] slice_add(
    input logic [WIDTH-1:0]     a,
    input logic [WIDTH-1:0]     b,
    input logic [WIDTH-1:0]     sum_in,
    input logic                 cin,
    input logic [KEY_WIDTH-1:0] key,
    input int                   slice
  );
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] sum;
    logic [3:0]       gl;
    logic [3:0]       pl;
    logic [4:0]       cl;
    logic             c;
    logic             gg;
    logic             gp;
    int               base;
    g = a & b;
    p = a ^ b;
    for (int j = 0; j < KEY_WIDTH; j++) begin
      if (CORRECT_KEY[j]) g[j % WIDTH] = g[j % WIDTH] & key[j];
      else                g[j % WIDTH] = g[j % WIDTH] | key[j];
    end
    sum = sum_in;
    c   = cin;
    for (int n = 0; n < GROUPS; n++) begin
      base  = slice * SLICE_W + n * 4;
      gl    = g[base +: 4];
      pl    = p[base +: 4];
      cl[0] = c;
      cl[1] = gl[0] | (pl[0] & c);
      cl[2] = gl[1] | (pl[1] & gl[0]) | (pl[1] & pl[0] & c);
      cl[3] = gl[2] | (pl[2] & gl[1]) | (pl[2] & pl[1] & gl[0])
            | (pl[2] & pl[1] & pl[0] & c);
      gg    = gl[3] | (pl[3] & gl[2]) | (pl[3] & pl[2] & gl[1])
            | (pl[3] & pl[2] & pl[1] & gl[0]);
      gp    = &pl;
      cl[4] = gg | (gp & c);
      sum[base +: 4] = pl ^ cl[3:0];
      c     = cl[4];
    end
    return {c, sum};
  endfunction

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [WIDTH:0] stage_out;

    assign stage_out = slice_add(st_a[s], st_b[s], st_sum[s], st_c[s], key_q, s);

    if (s < STAGES - 1) begin : g_mid
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] sum_q;
      logic             c_q;
      logic             v_q;

      // Inter-slice register: a key shift drops the beat, a stall holds it,
      // and data only moves when a valid beat moves.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          a_q   <= '0;
          b_q   <= '0;
          sum_q <= '0;
          c_q   <= 1'b0;
          v_q   <= 1'b0;
        end else begin
          if (key_shift_i)  v_q <= 1'b0;
          else if (advance) v_q <= st_v[s];
          if (advance && st_v[s] && !key_shift_i) begin
            a_q   <= st_a[s];
            b_q   <= st_b[s];
            sum_q <= stage_out[WIDTH-1:0];
            c_q   <= stage_out[WIDTH];
          end
        end
      end

      assign st_a[s+1]   = a_q;
      assign st_b[s+1]   = b_q;
      assign st_sum[s+1] = sum_q;
      assign st_c[s+1]   = c_q;
      assign st_v[s+1]   = v_q;
    end else begin : g_last
      // Output register: result only changes when a valid beat lands, so it
      // keeps the last good value while out_valid_o is low.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          out_valid_q <= 1'b0;
          result_q    <= '0;
        end else begin
          if (key_shift_i)  out_valid_q <= 1'b0;
          else if (advance) out_valid_q <= st_v[s];
          if (advance && st_v[s] && !key_shift_i) result_q <= stage_out;
        end
      end
    end
  end

  assign key_armed_o = armed_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;

endmodule

// File: tb/tb_carry_lookahead_adder_aor_pipe.sv
// ---------------------------------------------------------------------------
// tb_carry_lookahead_adder_aor_pipe
//
// Self-checking bench for carry_lookahead_adder_aor_pipe (default parameters).
// A scoreboard queue holds the expected result of every accepted beat; with
// the correct key the expected value is simply A+B, the locked-key vectors
// carry their expected values in a table. Directed sequences cover reset,
// key loading, flush on key shift, reset in flight and (with
// CLA_BACKPRESSURE_EN) output stalls.
// ---------------------------------------------------------------------------
module tb_carry_lookahead_adder_aor_pipe;

  localparam int WIDTH     = 16;
  localparam int STAGES    = 2;
  localparam int KEY_WIDTH = 32;
  localparam logic [31:0] CORRECT_KEY = 32'hD7D41D23;

  logic        clk_i       = 1'b0;
  logic        rst_ni      = 1'b0;
  logic        key_sin_i   = 1'b0;
  logic        key_shift_i = 1'b0;
  logic        in_valid_i  = 1'b0;
  logic [15:0] add1_i      = '0;
  logic [15:0] add2_i      = '0;
  logic        key_armed_o;
  logic        in_ready_o;
  logic        out_valid_o;
  logic [16:0] result_o;
`ifdef CLA_BACKPRESSURE_EN
  logic        out_ready_i = 1'b1;
`endif

  carry_lookahead_adder_aor_pipe #(
    .WIDTH(WIDTH),
    .STAGES(STAGES),
    .KEY_WIDTH(KEY_WIDTH),
    .CORRECT_KEY(CORRECT_KEY)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .key_sin_i(key_sin_i),
    .key_shift_i(key_shift_i),
    .key_armed_o(key_armed_o),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .add1_i(add1_i),
    .add2_i(add2_i),
    .out_valid_o(out_valid_o),
`ifdef CLA_BACKPRESSURE_EN
    .out_ready_i(out_ready_i),
`endif
    .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks       = 0;
  int          failures     = 0;
  int          cyc          = 0;
  int          outputs_seen = 0;
  logic [16:0] cur_expect   = '0;
  logic [16:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [31:0] loaded_key   = '0;
  bit          have_key     = 1'b0;

  typedef struct {
    logic [31:0] key;
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard push: record every accepted beat; a key shift or reset drops
  // everything still in flight.
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (!rst_ni || key_shift_i) begin
      exp_q.delete();
      exp_cyc_q.delete();
    end else if (in_valid_i && in_ready_o) begin
      exp_q.push_back(cur_expect);
      exp_cyc_q.push_back(cyc);
    end
  end

  // Scoreboard pop: compare each delivered beat in order.
  always @(negedge clk_i) begin
`ifdef CLA_BACKPRESSURE_EN
    if (rst_ni && out_valid_o && out_ready_i) begin
`else
    if (rst_ni && out_valid_o) begin
`endif
      if (exp_q.size() == 0) begin
        check_output("unexpected_valid", 32'(out_valid_o), 32'd0);
      end else begin
        check_output("sb_result", 32'(result_o), 32'(exp_q[0]));
`ifndef CLA_BACKPRESSURE_EN
        check_output("sb_latency", 32'(cyc - exp_cyc_q[0]), 32'(STAGES));
`endif
        exp_q.pop_front();
        exp_cyc_q.pop_front();
        outputs_seen++;
      end
    end
  end

  // Shift key bits k[top] down to k[0]; armed must stay low until the last.
  task automatic shift_bits(input logic [31:0] k, input int top);
    for (int i = top; i >= 0; i--) begin
      key_shift_i = 1'b1;
      key_sin_i   = k[i];
      tick();
      if (i != 0) check_output("armed_while_loading", 32'(key_armed_o), 32'd0);
    end
    key_shift_i = 1'b0;
    #1;
    check_output("armed_after_load", 32'(key_armed_o), 32'd1);
    check_output("ready_after_load", 32'(in_ready_o), 32'd1);
    loaded_key = k;
    have_key   = 1'b1;
  endtask

  task automatic load_key(input logic [31:0] k);
    shift_bits(k, KEY_WIDTH - 1);
  endtask

  task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b,
                                input logic [16:0] e);
    add1_i     = a;
    add2_i     = b;
    cur_expect = e;
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
  endtask

  initial begin
    int seen_before;
    logic [15:0] ra;
    logic [15:0] rb;

    vecs[0] = '{CORRECT_KEY,  16'h0020, 16'h0020, 17'h00040};
    vecs[1] = '{CORRECT_KEY,  16'hFFFF, 16'h0001, 17'h10000};
    vecs[2] = '{CORRECT_KEY,  16'h00FF, 16'h0001, 17'h00100};
    vecs[3] = '{CORRECT_KEY,  16'hFFFF, 16'hFFFF, 17'h1FFFE};
    vecs[4] = '{32'hD7D41D03, 16'h0020, 16'h0020, 17'h00000};
    vecs[5] = '{32'h00000000, 16'hFFFF, 16'hFFFF, 17'h04010};
    vecs[6] = '{32'hFFFFFFFF, 16'h0000, 16'h0000, 17'h1D5FE};
    vecs[7] = '{CORRECT_KEY,  16'h0000, 16'h0000, 17'h00000};

    // Reset, then 20 idle cycles with operands offered but no key.
    in_valid_i = 1'b1;
    add1_i     = 16'h1234;
    add2_i     = 16'h4321;
    repeat (3) tick();
    check_output("reset_result", 32'(result_o), 32'd0);
    check_output("reset_valid", 32'(out_valid_o), 32'd0);
    rst_ni = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_output("unkeyed_ready", 32'(in_ready_o), 32'd0);
      check_output("unkeyed_valid", 32'(out_valid_o), 32'd0);
      check_output("unkeyed_armed", 32'(key_armed_o), 32'd0);
    end
    in_valid_i = 1'b0;

    // Table-driven vectors, including locked (wrong) keys.
    for (int i = 0; i < 8; i++) begin
      if (!have_key || vecs[i].key != loaded_key) load_key(vecs[i].key);
      apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].exp);
      tick();
      check_output("vec_valid", 32'(out_valid_o), 32'd1);
      check_output("vec_result", 32'(result_o), 32'(vecs[i].exp));
      tick();
      check_output("vec_valid_drop", 32'(out_valid_o), 32'd0);
      check_output("vec_hold", 32'(result_o), 32'(vecs[i].exp));
    end

    // Back-to-back random operands with the correct key.
    if (loaded_key != CORRECT_KEY) load_key(CORRECT_KEY);
    seen_before = outputs_seen;
    in_valid_i  = 1'b1;
    for (int n = 0; n < 5000; n++) begin
      ra         = 16'($urandom);
      rb         = 16'($urandom);
      add1_i     = ra;
      add2_i     = rb;
      cur_expect = 17'(ra) + 17'(rb);
      tick();
    end
    in_valid_i = 1'b0;
    repeat (STAGES + 2) tick();
    check_output("random_count", 32'(outputs_seen - seen_before), 32'd5000);
    check_output("random_queue_empty", 32'(exp_q.size()), 32'd0);

    // Key shift with a beat in flight: the beat is dropped, reload needed.
    apply_stimulus(16'h1234, 16'h1111, 17'h02345);
    add1_i      = 16'h0F0F;
    add2_i      = 16'h0101;
    in_valid_i  = 1'b1;
    key_shift_i = 1'b1;
    key_sin_i   = CORRECT_KEY[31];
    #1;
    check_output("ready_during_shift", 32'(in_ready_o), 32'd0);
    tick();
    key_shift_i = 1'b0;
    in_valid_i  = 1'b0;
    check_output("armed_after_flush", 32'(key_armed_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_output("flush_dropped", 32'(out_valid_o), 32'd0);
    end
    shift_bits(CORRECT_KEY, KEY_WIDTH - 2);
    apply_stimulus(16'h0020, 16'h0020, 17'h00040);
    tick();
    check_output("reload_result", 32'(result_o), 32'h00040);

    // Reset with a beat in flight: everything lost.
    apply_stimulus(16'h7000, 16'h9000, 17'h10000);
    rst_ni = 1'b0;
    #1;
    check_output("midreset_valid", 32'(out_valid_o), 32'd0);
    check_output("midreset_armed", 32'(key_armed_o), 32'd0);
    check_output("midreset_result", 32'(result_o), 32'd0);
    repeat (2) tick();
    rst_ni   = 1'b1;
    have_key = 1'b0;
    tick();
    apply_stimulus(16'h0001, 16'h0001, 17'h00002);
    repeat (3) begin
      tick();
      check_output("after_reset_no_output", 32'(out_valid_o), 32'd0);
    end
    load_key(CORRECT_KEY);

`ifdef CLA_BACKPRESSURE_EN
    // Output stall for 5 cycles with two beats queued.
    out_ready_i = 1'b0;
    add1_i      = 16'h1000;
    add2_i      = 16'h0234;
    cur_expect  = 17'h01234;
    in_valid_i  = 1'b1;
    tick();
    add1_i      = 16'hF000;
    add2_i      = 16'h2000;
    cur_expect  = 17'h11000;
    tick();
    add1_i      = 16'h5555;
    add2_i      = 16'h5555;
    cur_expect  = 17'h0AAAA;
    for (int i = 0; i < 5; i++) begin
      check_output("stall_ready", 32'(in_ready_o), 32'd0);
      tick();
      check_output("stall_valid", 32'(out_valid_o), 32'd1);
      check_output("stall_result", 32'(result_o), 32'h01234);
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    tick();
    check_output("stall_second_valid", 32'(out_valid_o), 32'd1);
    check_output("stall_second_result", 32'(result_o), 32'h11000);
    tick();
    check_output("stall_no_duplicate", 32'(out_valid_o), 32'd0);
    repeat (2) tick();
    check_output("stall_queue_empty", 32'(exp_q.size()), 32'd0);
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
